// File: rtl/semaphore_arbiter_if.sv
// Request/ownership bus between cores and the semaphore arbiter.
// Vector bit s*NumberOfCores+c belongs to semaphore s, core c.
interface semaphore_arbiter_if #(
  parameter int NumberOfSemaphores = 4,
  parameter int NumberOfCores      = 2
);
  localparam int SC = NumberOfSemaphores * NumberOfCores;

  logic [SC-1:0]                 SEMAPHOREARBITER_acquire;
  logic [SC-1:0]                 SEMAPHOREARBITER_release;
  logic [SC-1:0]                 SEMAPHOREARBITER_owner;
  logic [NumberOfSemaphores-1:0] SEMAPHOREARBITER_busy;
  logic [SC-1:0]                 SEMAPHOREARBITER_grant;
  logic [SC-1:0]                 SEMAPHOREARBITER_error;
  logic [NumberOfSemaphores-1:0] SEMAPHOREARBITER_timeout;

  modport master (
    output SEMAPHOREARBITER_acquire, SEMAPHOREARBITER_release,
    input  SEMAPHOREARBITER_owner, SEMAPHOREARBITER_busy, SEMAPHOREARBITER_grant,
    input  SEMAPHOREARBITER_error, SEMAPHOREARBITER_timeout
  );

  modport slave (
    input  SEMAPHOREARBITER_acquire, SEMAPHOREARBITER_release,
    output SEMAPHOREARBITER_owner, SEMAPHOREARBITER_busy, SEMAPHOREARBITER_grant,
    output SEMAPHOREARBITER_error, SEMAPHOREARBITER_timeout
  );
endinterface

// File: rtl/semaphore_arbiter.sv
// Bank of independent hardware semaphores, each a FREE/LOCKED FSM with
// round-robin arbitration between cores and an optional hold timeout.
module semaphore_arbiter #(
  parameter int NumberOfSemaphores = 4,
  parameter int NumberOfCores      = 2,
  parameter int HoldTimeout        = 0
) (
  input  logic               CLK,
  input  logic               RST_N,
  semaphore_arbiter_if.slave sem
);
  localparam int S  = NumberOfSemaphores;
  localparam int C  = NumberOfCores;
  localparam int CW = (C > 1) ? $clog2(C) : 1;

  typedef enum logic {FREE = 1'b0, LOCKED = 1'b1} sem_state_e;

  // Arbitration is held off for the first edge after reset release, so the
  // earliest grant lands on the second rising edge.
  logic armed_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) armed_q <= 1'b0;
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    else        armed_q <= 1'b1;
  end

  for (genvar s = 0; s < S; s++) begin : g_sem
    sem_state_e     state_q, state_d;
    logic [C-1:0]   acq, rel;
    logic [C-1:0]   owner_q, owner_d;
    logic [C-1:0]   grant_q, grant_d;
    logic [C-1:0]   error_q, error_d;
    logic           timeout_q, timeout_d;
    logic [CW-1:0]  last_q, last_d;
    logic [CW-1:0]  cand, win_idx;
    logic           win_valid;
    logic           owner_rel;
    logic           hold_expired;

    assign acq       = sem.SEMAPHOREARBITER_acquire[s*C +: C];
    assign rel       = sem.SEMAPHOREARBITER_release[s*C +: C];
    assign owner_rel = |(rel & owner_q);

    // Round-robin search starting one past the last granted core.
    always_comb begin
      // NOTE: every variable gets a default before any branch, otherwise
      // paths that skip an assignment would infer a latch.
      cand      = '0;
      win_idx   = '0;
      win_valid = 1'b0;
      for (int i = 0; i < C; i++) begin
        cand = CW'((int'(last_q) + 1 + i) % C);
        if (!win_valid && acq[cand]) begin
          win_valid = 1'b1;
          win_idx   = cand;
        end
      end
    end

    always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      grant_d   = '0;
      error_d   = '0;
      timeout_d = 1'b0;
      unique case (state_q)
        FREE: begin
          error_d = rel;
          if (armed_q && win_valid) begin
            state_d          = LOCKED;
            owner_d          = '0;
            owner_d[win_idx] = 1'b1;
            grant_d          = owner_d;
            last_d           = win_idx;
          end
        end
        LOCKED: begin
          // Owner acquires are ignored; other cores' acquires stay pending
          // and are only arbitrated after a cycle spent FREE.
          error_d = rel & ~owner_q;
          if (owner_rel) begin
            state_d = FREE;
            owner_d = '0;
          end else if (hold_expired) begin
            state_d   = FREE;
            owner_d   = '0;
            timeout_d = 1'b1;
          end
        end
        default: state_d = FREE;
      endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state_q   <= FREE;
        owner_q   <= '0;
        grant_q   <= '0;
        error_q   <= '0;
        timeout_q <= 1'b0;
        last_q    <= CW'(C - 1);
      end else begin
        state_q   <= state_d;
        owner_q   <= owner_d;
        grant_q   <= grant_d;
        error_q   <= error_d;
        timeout_q <= timeout_d;
        last_q    <= last_d;
      end
    end

    if (HoldTimeout > 0) begin : g_hold
      localparam int TW = $clog2(HoldTimeout + 1);
      logic [TW-1:0] hold_q;

      // hold_q counts completed LOCKED cycles; the owner is forced out at the
      // edge that completes the HoldTimeout-th cycle.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
          hold_q <= '0;
        else if (grant_d != '0)
          hold_q <= '0;
        else if (state_q == LOCKED && hold_q != TW'(HoldTimeout))
          hold_q <= hold_q + 1'b1;
      end

      assign hold_expired = (state_q == LOCKED) && (hold_q == TW'(HoldTimeout - 1));
    end else begin : g_no_hold
      assign hold_expired = 1'b0;
    end

    assign sem.SEMAPHOREARBITER_owner[s*C +: C] = owner_q;
    assign sem.SEMAPHOREARBITER_grant[s*C +: C] = grant_q;
    assign sem.SEMAPHOREARBITER_error[s*C +: C] = error_q;
    assign sem.SEMAPHOREARBITER_busy[s]         = (state_q == LOCKED);
    assign sem.SEMAPHOREARBITER_timeout[s]      = timeout_q;
  end
endmodule

// File: doc/semaphore_arbiter.md
SEMAPHORE_ARBITER -- requirements
Module: semaphore_arbiter

Interface
REQ-001 Parameter NumberOfSemaphores, default 4, number of independent hardware semaphores.
REQ-002 Parameter NumberOfCores, default 2, number of requesting cores.
REQ-003 Parameter HoldTimeout, default 0, maximum cycles a core may own a semaphore (0 disables timeout).
REQ-004 Bit index convention for all S*C vectors: bit s*NumberOfCores+c (semaphore s, core c).
REQ-005 CLK  input  1  single clock; all state changes on its rising edge.
REQ-006 RST_N  input  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low).
REQ-007 SEMAPHOREARBITER_acquire  input  S*C  level acquire request per core per semaphore.
REQ-008 SEMAPHOREARBITER_release  input  S*C  single-cycle release strobe per core per semaphore.
REQ-009 SEMAPHOREARBITER_owner  output  S*C  registered one-hot-or-zero owner per semaphore; drives the semaphore write-enable lines.
REQ-010 SEMAPHOREARBITER_busy  output  S  registered; 1 when semaphore s has an owner.
REQ-011 SEMAPHOREARBITER_grant  output  S*C  one-cycle pulse in the cycle owner bit first rises.
REQ-012 SEMAPHOREARBITER_error  output  S*C  one-cycle pulse on illegal release (non-owner release).
REQ-013 SEMAPHOREARBITER_timeout  output  S  one-cycle pulse when a hold timeout forces release.

Function
REQ-014 Each semaphore SHALL run an independent two-state FSM: FREE, LOCKED.
REQ-015 FREE -> LOCKED: at least one acquire bit of semaphore s high in cycle N; owner, busy, grant high after edge N+1 (one-cycle latency).
REQ-016 Arbitration SHALL be round-robin per semaphore: search starts at core (last_granted+1) mod NumberOfCores, wraps, first requester wins.
REQ-017 last_granted pointer SHALL update only on a grant; reset value NumberOfCores-1 so core 0 has first priority.
REQ-018 LOCKED -> FREE: release bit of current owner high; owner and busy cleared after the edge.
REQ-019 Release and acquire of the same semaphore in the same cycle: release wins, semaphore is FREE for exactly one cycle, arbitration occurs in the following cycle (no same-cycle handover).
REQ-020 Release by a non-owner core SHALL be ignored and pulse error for that core/semaphore; simultaneous owner release still takes effect.
REQ-021 Release on a FREE semaphore SHALL pulse error for the releasing core.
REQ-022 Acquire by the current owner while LOCKED SHALL have no effect; acquires by others remain pending (level) until granted or dropped.
REQ-023 Acquire dropped before grant SHALL leave no residual state.
REQ-024 At most one owner bit per semaphore SHALL ever be high.
REQ-025 With HoldTimeout>0, a per-semaphore counter of width $clog2(HoldTimeout+1) SHALL clear on grant and increment each LOCKED cycle, saturating.
REQ-026 When counter reaches HoldTimeout while LOCKED and no owner release in that cycle: force FREE, pulse timeout[s]; owner release in the same cycle takes priority with no timeout pulse.
REQ-027 With HoldTimeout=0 counters SHALL not be instantiated and timeout SHALL stay 0.

Reset
REQ-028 RST_N low SHALL immediately clear owner, busy, grant, error, timeout, counters; all FSMs to FREE; pointers to NumberOfCores-1.
REQ-029 Reset asserted mid-ownership SHALL drop ownership with no grant/timeout/error pulse; first grant possible on the second rising edge after RST_N deasserts.

Verification
REQ-030 Reset, acquire[0] (sem0,core0) high at cycle 2 -> owner[0]=1, busy[0]=1, grant[0] pulse at cycle 3.
REQ-031 Cores 0 and 1 request sem1 together, core0 releases after 5 cycles -> core0 granted first, sem1 FREE one cycle, core1 granted; repeat -> core0 next (round-robin alternates).
REQ-032 Core1 releases sem2 owned by core0 -> error[5] pulse, owner[4] stays 1, busy[2] stays 1.
REQ-033 HoldTimeout=8, core0 holds sem3 -> timeout[3] pulse and owner[6] clears on 8th LOCKED cycle; release in that same cycle -> no timeout pulse.
REQ-034 RST_N pulsed low while all four semaphores LOCKED -> all outputs 0 asynchronously, no pulses, pointers restored (core0 priority).
REQ-035 Random acquire/release on all S*C bits for 10000 cycles -> owner never has more than one bit per semaphore; no requester starved beyond NumberOfCores grants.
